div_job_sequencer: RTL and testbench

Front-end sequencer that sits directly upstream of the 6-bit restoring divider datapath and controller.
- Accepts dividend/divisor jobs over a valid/ready handshake and holds the operands stable.
- Issues a single-cycle start to the divider, waits for Done, and captures the quotient and remainder.
- Presents each result downstream with valid/ready, a divide-by-zero flag and a timeout error flag.

---
 rtl/div_job_sequencer_pkg.sv | 24 ++
 rtl/div_job_sequencer_timeout.sv | 48 ++++
 rtl/div_job_sequencer.sv | 167 ++++++++++++++++
 tb/tb_div_job_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_job_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// div_job_sequencer_pkg
// Shared definitions for the divider job sequencer:
//   - default operand width and timeout limit
//   - sequencer state encoding (3-bit)
//   - divide-by-zero quotient pattern (all ones, sliced to WIDTH by users)
// ---------------------------------------------------------------------------
package div_job_sequencer_pkg;

   localparam int DEF_WIDTH   = 6;
   localparam int DEF_TIMEOUT = 31;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

   // Wide all-ones word; users take the low WIDTH bits.
   localparam logic [31:0] DZ_QUOTIENT_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_job_sequencer_timeout.sv
// ---------------------------------------------------------------------------
// div_timeout_counter
// Counts cycles spent waiting on the divider.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears the count
//   clr_i  : clear count to zero (priority over en_i)
//   en_i   : increment count by one
//   tc_o   : terminal count; high while the count equals TERMINAL-1, i.e.
//            during the TERMINAL-th enabled cycle after a clear
// ---------------------------------------------------------------------------
module div_timeout_counter
   import div_job_sequencer_pkg::*;
#(
   parameter int TERMINAL = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = $clog2(TERMINAL + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == CW'(TERMINAL - 1));

endmodule

// File: rtl/div_job_sequencer.sv
// ---------------------------------------------------------------------------
// div_job_sequencer
// Front end for a restoring divider: accepts dividend/divisor jobs, issues a
// one-cycle start, waits for Done (or a timeout), and presents the captured
// result with divide-by-zero and timeout flags.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : job handshake
//   in_dividend/in_divisor    : job operands
//   div_start                 : one-cycle start pulse to the divider
//   div_dividend/div_divisor  : operands held for the whole job
//   div_done                  : divider Done (high two cycles per job)
//   div_quotient/remainder    : divider results, valid with div_done
//   out_valid/out_ready       : result handshake
//   out_quotient/remainder    : registered result
//   out_dz, out_err           : divide-by-zero and timeout flags
// ---------------------------------------------------------------------------
module div_job_sequencer
   import div_job_sequencer_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic             div_start,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_dz,
   output logic             out_err
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, dz_d;
   logic             err_q, err_d;

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_tc;

   div_timeout_counter #(
      .TERMINAL (TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dz_d       = dz_q;
      err_d      = err_q;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_divisor != '0) begin
                  dividend_d = in_dividend;
                  divisor_d  = in_divisor;
                  state_d    = S_START;
               end else begin
                  // Zero divisor is answered locally; the divider never runs.
                  quot_d  = DZ_QUOTIENT_ALL[WIDTH-1:0];
                  rem_d   = in_dividend;
                  dz_d    = 1'b1;
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end
            end
         end

         S_START: begin
            cnt_clr = 1'b1;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            cnt_en = 1'b1;
            if (div_done) begin
               quot_d  = div_quotient;
               rem_d   = div_remainder;
               dz_d    = 1'b0;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_tc) begin
               quot_d  = '0;
               rem_d   = '0;
               dz_d    = 1'b0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            // If Done is still up, its second cycle must not leak into the
            // next job, so wait it out in S_DRAIN.
            if (out_ready) begin
               state_d = div_done ? S_DRAIN : S_IDLE;
            end
         end

         S_DRAIN: begin
            if (!div_done) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         dz_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dz_q       <= dz_d;
         err_q      <= err_d;
      end
   end

   assign in_ready      = (state_q == S_IDLE);
   assign out_valid     = (state_q == S_RESP);
   assign div_start     = (state_q == S_START);
   assign div_dividend  = dividend_q;
   assign div_divisor   = divisor_q;
   assign out_quotient  = quot_q;
   assign out_remainder = rem_q;
   assign out_dz        = dz_q;
   assign out_err       = err_q;

endmodule

// File: tb/tb_div_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_job_sequencer
// Self-checking bench: a behavioural divider (Done 22 cycles after the start
// cycle, held 2 cycles) drives the sequencer; expected results come from
// plain integer division in the bench.
// ---------------------------------------------------------------------------
module tb_div_job_sequencer;

   localparam int W   = 6;
   localparam int TO  = 31;
   localparam int LAT = 22;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_dividend;
   logic [W-1:0] in_divisor;
   logic         div_start;
   logic [W-1:0] div_dividend;
   logic [W-1:0] div_divisor;
   logic         div_done;
   logic [W-1:0] div_quotient;
   logic [W-1:0] div_remainder;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_quotient;
   logic [W-1:0] out_remainder;
   logic         out_dz;
   logic         out_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_job_sequencer #(
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .in_divisor    (in_divisor),
      .div_start     (div_start),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_done      (div_done),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_dz        (out_dz),
      .out_err       (out_err)
   );

   // ---------------- behavioural divider ----------------
   int           dcnt = 0;
   logic [W-1:0] m_dd = '0;
   logic [W-1:0] m_dv = '0;
   bit           never_done = 1'b0;

   always @(posedge clk) begin
      if (div_start) begin
         dcnt <= 1;
         m_dd <= div_dividend;
         m_dv <= div_divisor;
      end else if (dcnt != 0) begin
         dcnt <= (dcnt >= LAT + 1) ? 0 : dcnt + 1;
      end
   end

   assign div_done      = !never_done && (dcnt == LAT || dcnt == LAT + 1);
   assign div_quotient  = (m_dv == 0) ? '0 : W'(m_dd / m_dv);
   assign div_remainder = (m_dv == 0) ? '0 : W'(m_dd % m_dv);

   // ---------------- monitors ----------------
   int   valid_rises = 0;
   logic ov_prev     = 1'b0;
   bit   mon_en      = 1'b0;
   bit   ready_with_done = 1'b0;

   always @(negedge clk) begin
      ov_prev <= out_valid;
      if (out_valid && !ov_prev) valid_rises <= valid_rises + 1;
      if (mon_en && in_ready && div_done) ready_with_done <= 1'b1;
   end

   // ---------------- job driver (no checking) ----------------
   task automatic do_job(input logic [W-1:0] dd, input logic [W-1:0] dv, input int hold,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic err,
                         output int start_cnt, output int done_at, output int valid_at,
                         output bit stable, output bit timed_out, output bit done_at_accept);
      int k;
      timed_out = 1'b0; stable = 1'b1; start_cnt = 0; done_at = -1; valid_at = -1;
      q = '0; r = '0; dz = 1'b0; err = 1'b0; done_at_accept = 1'b0;
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk); k++;
      end
      if (!in_ready) begin
         timed_out = 1'b1;
         return;
      end
      done_at_accept = div_done;
      in_valid = 1'b1; in_dividend = dd; in_divisor = dv;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (k < 200) begin
         if (div_start) start_cnt++;
         if (div_done && done_at < 0) done_at = k;
         if (out_valid) break;
         if (in_ready) stable = 1'b0;
         if (dv != 0 && (div_dividend !== dd || div_divisor !== dv)) stable = 1'b0;
         @(negedge clk); k++;
      end
      if (!out_valid) begin
         timed_out = 1'b1;
         return;
      end
      valid_at = k; q = out_quotient; r = out_remainder; dz = out_dz; err = out_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!out_valid || out_quotient !== q || out_remainder !== r ||
             out_dz !== dz || out_err !== err || in_ready || div_start) stable = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_dividend = '0; in_divisor = '0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %0d expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %0d expected 0", out_valid); end
      checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset div_start: got %0d expected 0", div_start); end
      checks++; if (out_dz !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL reset flags: got dz=%0d err=%0d expected 0 0", out_dz, out_err); end
      checks++; if (out_quotient !== '0 || out_remainder !== '0) begin errors++; $display("FAIL reset result regs: got %0d r%0d expected 0 r0", out_quotient, out_remainder); end
      checks++; if (div_dividend !== '0 || div_divisor !== '0) begin errors++; $display("FAIL reset operand regs: got %0d/%0d expected 0/0", div_dividend, div_divisor); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post-reset idle: got ready=%0d valid=%0d expected 1 0", in_ready, out_valid); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [W-1:0] q, r; logic dz, err; int sc, da, va; bit st, tmo, dacc;
      do_job(6'd45, 6'd6, 0, q, r, dz, err, sc, da, va, st, tmo, dacc);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL basic bound: got timeout=%0d expected 0", tmo); end
      checks++; if (sc !== 1) begin errors++; $display("FAIL basic start count: got %0d expected 1", sc); end
      checks++; if (q !== 6'd7 || r !== 6'd3) begin errors++; $display("FAIL basic 45/6: got %0d r%0d expected 7 r3", q, r); end
      checks++; if (dz !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic flags: got dz=%0d err=%0d expected 0 0", dz, err); end
      checks++; if (da !== LAT) begin errors++; $display("FAIL basic done cycle: got %0d expected %0d", da, LAT); end
      checks++; if (va !== LAT + 1) begin errors++; $display("FAIL basic valid cycle: got %0d expected %0d", va, LAT + 1); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL basic stability: got %0d expected 1", st); end
      $display("test_basic 45/6 -> %0d r%0d dz=%0d err=%0d valid_at=%0d", q, r, dz, err, va);
   endtask

   task automatic test_div_zero();
      logic [W-1:0] q, r; logic dz, err; int sc, da, va; bit st, tmo, dacc;
      do_job(6'd17, 6'd0, 2, q, r, dz, err, sc, da, va, st, tmo, dacc);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL dz bound: got timeout=%0d expected 0", tmo); end
      checks++; if (sc !== 0) begin errors++; $display("FAIL dz start count: got %0d expected 0", sc); end
      checks++; if (va !== 0) begin errors++; $display("FAIL dz valid cycle: got %0d expected 0", va); end
      checks++; if (q !== 6'd63 || r !== 6'd17) begin errors++; $display("FAIL dz 17/0: got %0d r%0d expected 63 r17", q, r); end
      checks++; if (dz !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL dz flags: got dz=%0d err=%0d expected 1 0", dz, err); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL dz stability: got %0d expected 1", st); end
      $display("test_div_zero 17/0 -> %0d r%0d dz=%0d err=%0d", q, r, dz, err);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] q, r; logic dz, err; int sc, da, va; bit st, tmo, dacc; int rises0;
      logic [W-1:0] ta [2]; logic [W-1:0] tb [2];
      ta[0] = 6'd63; tb[0] = 6'd1; ta[1] = 6'd20; tb[1] = 6'd7;
      rises0 = valid_rises; ready_with_done = 1'b0; mon_en = 1'b1;
      for (int j = 0; j < 2; j++) begin
         do_job(ta[j], tb[j], 0, q, r, dz, err, sc, da, va, st, tmo, dacc);
         checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL b2b%0d bound: got timeout=%0d expected 0", j, tmo); end
         checks++; if (q !== ta[j] / tb[j] || r !== ta[j] % tb[j]) begin errors++; $display("FAIL b2b%0d result: got %0d r%0d expected %0d r%0d", j, q, r, ta[j] / tb[j], ta[j] % tb[j]); end
         checks++; if (sc !== 1) begin errors++; $display("FAIL b2b%0d start count: got %0d expected 1", j, sc); end
         checks++; if (dacc !== 1'b0) begin errors++; $display("FAIL b2b%0d accept during done: got %0d expected 0", j, dacc); end
         $display("test_back_to_back job%0d %0d/%0d -> %0d r%0d", j, ta[j], tb[j], q, r);
      end
      repeat (5) @(negedge clk);
      mon_en = 1'b0;
      checks++; if (valid_rises - rises0 !== 2) begin errors++; $display("FAIL b2b result count: got %0d expected 2", valid_rises - rises0); end
      checks++; if (ready_with_done !== 1'b0) begin errors++; $display("FAIL b2b ready while done: got %0d expected 0", ready_with_done); end
   endtask

   task automatic test_hold();
      logic [W-1:0] q, r; logic dz, err; int sc, da, va; bit st, tmo, dacc;
      do_job(6'd9, 6'd4, 10, q, r, dz, err, sc, da, va, st, tmo, dacc);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL hold bound: got timeout=%0d expected 0", tmo); end
      checks++; if (q !== 6'd2 || r !== 6'd1) begin errors++; $display("FAIL hold 9/4: got %0d r%0d expected 2 r1", q, r); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL hold stability: got %0d expected 1", st); end
      $display("test_hold 9/4 -> %0d r%0d stable=%0d", q, r, st);
   endtask

   task automatic test_timeout();
      logic [W-1:0] q, r; logic dz, err; int sc, da, va; bit st, tmo, dacc;
      never_done = 1'b1;
      do_job(6'd40, 6'd3, 1, q, r, dz, err, sc, da, va, st, tmo, dacc);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL timeout bound: got timeout=%0d expected 0", tmo); end
      checks++; if (va !== TO + 1) begin errors++; $display("FAIL timeout valid cycle: got %0d expected %0d", va, TO + 1); end
      checks++; if (q !== '0 || r !== '0) begin errors++; $display("FAIL timeout result: got %0d r%0d expected 0 r0", q, r); end
      checks++; if (err !== 1'b1 || dz !== 1'b0) begin errors++; $display("FAIL timeout flags: got dz=%0d err=%0d expected 0 1", dz, err); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL timeout return idle: got ready=%0d valid=%0d expected 1 0", in_ready, out_valid); end
      never_done = 1'b0;
      repeat (30) @(negedge clk);
      $display("test_timeout 40/3 -> %0d r%0d err=%0d valid_at=%0d", q, r, err, va);
   endtask

   task automatic test_reset_mid_job();
      logic [W-1:0] q, r; logic dz, err; int sc, da, va; bit st, tmo, dacc;
      in_valid = 1'b1; in_dividend = 6'd50; in_divisor = 6'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midjob busy: got ready=%0d expected 0", in_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL midjob reset: got ready=%0d valid=%0d start=%0d expected 1 0 0", in_ready, out_valid, div_start); end
      repeat (30) @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stale done ignored: got valid=%0d ready=%0d expected 0 1", out_valid, in_ready); end
      do_job(6'd12, 6'd5, 0, q, r, dz, err, sc, da, va, st, tmo, dacc);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL midjob bound: got timeout=%0d expected 0", tmo); end
      checks++; if (q !== 6'd2 || r !== 6'd2 || err !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL after reset 12/5: got %0d r%0d dz=%0d err=%0d expected 2 r2 0 0", q, r, dz, err); end
      $display("test_reset_mid_job 12/5 -> %0d r%0d", q, r);
   endtask

   task automatic test_random();
      logic [W-1:0] q, r; logic dz, err; int sc, da, va; bit st, tmo, dacc;
      logic [W-1:0] dd, dv, eq, er; logic edz; int eva, esc, hold;
      for (int j = 0; j < 24; j++) begin
         dd = W'($urandom_range(0, 63));
         dv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 63));
         hold = int'($urandom_range(0, 3));
         if (dv == 0) begin
            eq = 6'd63; er = dd; edz = 1'b1; eva = 0; esc = 0;
         end else begin
            eq = dd / dv; er = dd % dv; edz = 1'b0; eva = LAT + 1; esc = 1;
         end
         do_job(dd, dv, hold, q, r, dz, err, sc, da, va, st, tmo, dacc);
         checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rand%0d bound: got timeout=%0d expected 0", j, tmo); end
         checks++; if (q !== eq || r !== er) begin errors++; $display("FAIL rand%0d %0d/%0d: got %0d r%0d expected %0d r%0d", j, dd, dv, q, r, eq, er); end
         checks++; if (dz !== edz || err !== 1'b0) begin errors++; $display("FAIL rand%0d flags: got dz=%0d err=%0d expected %0d 0", j, dz, err, edz); end
         checks++; if (va !== eva || sc !== esc) begin errors++; $display("FAIL rand%0d timing: got valid_at=%0d starts=%0d expected %0d %0d", j, va, sc, eva, esc); end
         checks++; if (st !== 1'b1) begin errors++; $display("FAIL rand%0d stability: got %0d expected 1", j, st); end
         $display("test_random job%0d %0d/%0d hold=%0d -> %0d r%0d dz=%0d", j, dd, dv, hold, q, r, dz);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_back_to_back();
      test_hold();
      test_timeout();
      test_reset_mid_job();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
